rgb_ddr_writer: RTL

Parametrised RGB-to-DDR frame writer that sits between the pixel capture FIFO and one write port of the Spartan-6 MCB. It drains pixels from the FIFO in configurable bursts and zero-pads each pixel to a 32-bit word. After each burst it issues a write command with auto-precharge at a linearly advancing address. The address wraps at a configurable frame size, so successive frames overwrite one frame buffer, and a frame-start input realigns the address.

---
 rtl/rgb_ddr_writer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rgb_ddr_writer.sv
// rgb_ddr_writer: drains pixels from the capture FIFO in fixed-length bursts,
// zero-pads each pixel to a 32-bit word for an MCB write port and, after
// each burst, commands a write with auto-precharge at a linearly advancing
// address that wraps around one frame buffer.
module rgb_ddr_writer #(
    parameter int RGB_WIDTH        = 24,
    parameter int DATA_COUNT_WIDTH = 11,
    parameter int BURST_LEN        = 64,
    parameter int FRAME_BASE       = 0,
    parameter int FRAME_WORDS      = 786432
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        calib_done,
    output logic                        cmd_en,
    output logic [2:0]                  cmd_instr,
    output logic [5:0]                  cmd_bl,
    output logic [29:0]                 cmd_byte_addr,
    input  logic                        cmd_full,
    output logic                        wr_en,
    output logic [3:0]                  wr_mask,
    output logic [31:0]                 wr_data,
    input  logic                        wr_empty,
    input  logic                        wr_underrun,
    input  logic                        wr_error,
    input  logic [RGB_WIDTH-1:0]        fifo_data_out,
    output logic                        fifo_read_enable,
    input  logic [DATA_COUNT_WIDTH-1:0] fifo_rd_data_count,
    input  logic                        frame_start,
    output logic                        frame_done,
    output logic                        busy,
    output logic [15:0]                 error_count,
    output logic [7:0]                  led
);

    localparam logic [29:0] BASE_ADDR  = 30'(FRAME_BASE);
    localparam logic [29:0] ADDR_STEP  = 30'(4 * BURST_LEN);
    localparam logic [5:0]  BL_M1      = 6'(BURST_LEN - 1);
    localparam logic [6:0]  LAST_RD    = 7'(BURST_LEN - 1);
    localparam logic [31:0] BURST_W    = 32'(BURST_LEN);
    localparam logic [31:0] FRAME_W    = 32'(FRAME_WORDS);
    localparam logic [2:0]  INSTR_WRAP = 3'b010;

    typedef enum logic [2:0] {
        S_WAIT_CALIB,
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_CMD
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    rd_cnt_q, rd_cnt_d;
    logic          drain_q, drain_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   words_q, words_d;
    logic          pending_q, pending_d;
    logic          rd_en_q, rd_en_d;
    logic          rd_pend_q, rd_pend_d;
    logic          wr_en_q, wr_en_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          cmd_en_q, cmd_en_d;
    logic [2:0]    cmd_instr_q, cmd_instr_d;
    logic [5:0]    cmd_bl_q, cmd_bl_d;
    logic [29:0]   cmd_addr_q, cmd_addr_d;
    logic          frame_done_q, frame_done_d;
    logic [4:0]    frame_cnt_q, frame_cnt_d;
    logic          calib_q, calib_d;
    logic          sticky_q, sticky_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    // Next-state logic for the burst sequencer, pixel pipeline and status
    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        drain_d      = drain_q;
        addr_d       = addr_q;
        words_d      = words_q;
        pending_d    = pending_q | frame_start;
        rd_en_d      = 1'b0;
        rd_pend_d    = rd_en_q;
        wr_en_d      = rd_pend_q;
        wr_data_d    = wr_data_q;
        cmd_en_d     = 1'b0;
        cmd_instr_d  = cmd_instr_q;
        cmd_bl_d     = cmd_bl_q;
        cmd_addr_d   = cmd_addr_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        calib_d      = calib_q;
        sticky_d     = sticky_q;
        err_cnt_d    = err_cnt_q;

        if (rd_pend_q) begin
            wr_data_d = 32'(fifo_data_out);
        end

        if (wr_underrun || wr_error) begin
            sticky_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        case (state_q)
            S_WAIT_CALIB: begin
                if (calib_done) begin
                    state_d = S_IDLE;
                    calib_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (pending_q) begin
                    addr_d    = BASE_ADDR;
                    words_d   = '0;
                    pending_d = frame_start;
                end
                if ((32'(fifo_rd_data_count) >= BURST_W) && wr_empty) begin
                    state_d  = S_FILL;
                    rd_en_d  = 1'b1;
                    rd_cnt_d = '0;
                end
            end
            S_FILL: begin
                rd_cnt_d = rd_cnt_q + 7'd1;
                if (rd_cnt_q == LAST_RD) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    rd_en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (!cmd_full) begin
                    cmd_en_d    = 1'b1;
                    cmd_instr_d = INSTR_WRAP;
                    cmd_bl_d    = BL_M1;
                    cmd_addr_d  = addr_q;
                    state_d     = S_IDLE;
                    if (words_q + BURST_W == FRAME_W) begin
                        addr_d       = BASE_ADDR;
                        words_d      = '0;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 5'd1;
                    end else begin
                        addr_d  = addr_q + ADDR_STEP;
                        words_d = words_q + BURST_W;
                    end
                end
            end
            default: begin
                state_d = S_WAIT_CALIB;
            end
        endcase
    end

    // State and output registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_CALIB;
            rd_cnt_q     <= '0;
            drain_q      <= 1'b0;
            addr_q       <= BASE_ADDR;
            words_q      <= '0;
            pending_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            cmd_en_q     <= 1'b0;
            cmd_instr_q  <= '0;
            cmd_bl_q     <= '0;
            cmd_addr_q   <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            calib_q      <= 1'b0;
            sticky_q     <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            drain_q      <= drain_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            pending_q    <= pending_d;
            rd_en_q      <= rd_en_d;
            rd_pend_q    <= rd_pend_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            cmd_en_q     <= cmd_en_d;
            cmd_instr_q  <= cmd_instr_d;
            cmd_bl_q     <= cmd_bl_d;
            cmd_addr_q   <= cmd_addr_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            calib_q      <= calib_d;
            sticky_q     <= sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign busy             = (state_q != S_WAIT_CALIB) && (state_q != S_IDLE);
    assign cmd_en           = cmd_en_q;
    assign cmd_instr        = cmd_instr_q;
    assign cmd_bl           = cmd_bl_q;
    assign cmd_byte_addr    = cmd_addr_q;
    assign wr_en            = wr_en_q;
    assign wr_mask          = 4'b0000;
    assign wr_data          = wr_data_q;
    assign fifo_read_enable = rd_en_q;
    assign frame_done       = frame_done_q;
    assign error_count      = err_cnt_q;
    assign led              = {frame_cnt_q, sticky_q, busy, calib_q};

endmodule
